// File: rtl/mlp_pkg.sv
// Shared constants for the neuron accumulator / activation datapath.
// The accumulator width, the activation width and the activation saturation limits.
package mlp_pkg;

    localparam int ACC_W     = 21;
    localparam int ACT_W     = 8;
    localparam int ACC_SHIFT = 8;

    localparam int ACT_MAX = (2 ** (ACT_W - 1)) - 1;
    localparam int ACT_MIN = -(2 ** (ACT_W - 1));

endpackage : mlp_pkg

// File: rtl/acc_unloader_if.sv
// Handshake bundle for the unloader: the accumulator-side push port and the
// activation-side pop port.
interface acc_unloader_if
    import mlp_pkg::*;
#(
    parameter int N = ACC_W,
    parameter int M = ACT_W
);

    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] in_data;
    logic                relu_en;
    logic                out_valid;
    logic                out_ready;
    logic signed [M-1:0] out_data;
    logic                out_sat;

    modport slave (
        input  in_valid, in_data, relu_en, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

    modport master (
        output in_valid, in_data, relu_en, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

endinterface : acc_unloader_if

// File: rtl/acc_unloader_sat_shift.sv
// Rescales an accumulator sum with a flooring arithmetic shift, applies optional
// ReLU and saturates to the activation width.
module sat_shift
    import mlp_pkg::*;
#(
    parameter int N     = ACC_W,
    parameter int M     = ACT_W,
    parameter int SHIFT = ACC_SHIFT
) (
    input  logic signed [N-1:0] in_data,
    input  logic                relu_en,
    output logic signed [M-1:0] result,
    output logic                sat
);

    localparam int MAX_I = (2 ** (M - 1)) - 1;
    localparam int MIN_I = -(2 ** (M - 1));
    localparam logic signed [N-1:0] MAX_S = MAX_I[N-1:0];
    localparam logic signed [N-1:0] MIN_S = MIN_I[N-1:0];

    logic signed [N-1:0] shifted;

    // NOTE: combinational logic uses blocking assignments and gives every output
    // a default first, so no path can leave a value held and infer a latch.
    always_comb begin
        shifted = in_data >>> SHIFT;
        result  = shifted[M-1:0];
        sat     = 1'b0;
        // ReLU clamping is a deliberate zero, not an overflow.
        if (relu_en && shifted < 0) begin
            result = '0;
        end else if (shifted > MAX_S) begin
            result = MAX_S[M-1:0];
            sat    = 1'b1;
        end else if (shifted < MIN_S) begin
            result = MIN_S[M-1:0];
            sat    = 1'b1;
        end
    end

endmodule : sat_shift

// File: rtl/acc_unloader.sv
// Drain side of the accumulator path: converts finished sums to activations and
// buffers them in a small FIFO with a registered head for the next layer.
module acc_unloader
    import mlp_pkg::*;
#(
    parameter  int N     = ACC_W,
    parameter  int M     = ACT_W,
    parameter  int SHIFT = ACC_SHIFT,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    acc_unloader_if.slave    bus,
    output logic [CNT_W-1:0] count,
    output logic             sat_sticky,
    input  logic             sat_clr
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [M-1:0]     head_data_q, head_data_d;
    logic             head_sat_q, head_sat_d;
    logic             sat_sticky_q, sat_sticky_d;

    logic [M-1:0]     mem_data_q [DEPTH];
    logic             mem_sat_q  [DEPTH];

    logic signed [M-1:0] conv_data;
    logic                conv_sat;
    logic                push;
    logic                pop;

    sat_shift #(
        .N     (N),
        .M     (M),
        .SHIFT (SHIFT)
    ) u_sat_shift (
        .in_data (bus.in_data),
        .relu_en (bus.relu_en),
        .result  (conv_data),
        .sat     (conv_sat)
    );

    assign bus.in_ready  = (count_q < CNT_W'(DEPTH));
    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = head_data_q;
    assign bus.out_sat   = head_sat_q;
    assign count         = count_q;
    assign sat_sticky    = sat_sticky_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        head_data_d  = head_data_q;
        head_sat_d   = head_sat_q;
        sat_sticky_d = sat_sticky_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // The head reloads only when it is consumed or absent. A word being
        // written this cycle bypasses storage when it becomes the new head.
        if (pop || count_q == '0) begin
            if (push && rd_ptr_d == wr_ptr_q) begin
                head_data_d = conv_data;
                head_sat_d  = conv_sat;
            end else if (pop && count_d != '0) begin
                head_data_d = mem_data_q[rd_ptr_d];
                head_sat_d  = mem_sat_q[rd_ptr_d];
            end
        end

        if (push && conv_sat) sat_sticky_d = 1'b1;
        else if (sat_clr)     sat_sticky_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_data_q  <= '0;
            head_sat_q   <= 1'b0;
            sat_sticky_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_data_q  <= head_data_d;
            head_sat_q   <= head_sat_d;
            sat_sticky_q <= sat_sticky_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is only read after it has
    // been written, and the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= conv_data;
            mem_sat_q[wr_ptr_q]  <= conv_sat;
        end
    end

endmodule : acc_unloader

// File: doc/acc_unloader.md
# acc_unloader

Drain side of the neuron accumulator path. Accepts completed 21-bit signed accumulator sums over a valid/ready handshake, rescales each by an arithmetic right shift, optionally applies ReLU, and saturates to a signed 8-bit activation. Results are buffered in a small FIFO and streamed to the next layer's input register bank over a second valid/ready handshake. Sits between the accumulating registers and the next layer's input registers; it is the reader for the values the accumulators write.

## Interface
- `N`, 21, accumulator (input) width, two's complement
- `M`, 8, activation (output) width, two's complement
- `SHIFT`, 8, arithmetic right-shift amount applied before saturation (0..N-1)
- `DEPTH`, 4, FIFO entries, power of two, ≥2

- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  `in_data` holds a finished sum
- `in_ready`  out  1  unloader can accept; equals `count < DEPTH`
- `in_data`  in  N  signed accumulator sum
- `relu_en`  in  1  sampled with each accepted word; 1 = clamp negatives to 0
- `out_valid`  out  1  FIFO head is valid
- `out_ready`  in  1  consumer accepts head this cycle
- `out_data`  out  M  signed activation at FIFO head
- `out_sat`  out  1  head entry was saturated
- `count`  out  clog2(DEPTH+1)  entries held
- `sat_sticky`  out  1  set when any accepted word saturates
- `sat_clr`  in  1  clears `sat_sticky`

## Operation
- Push: `in_valid && in_ready`. Pop: `out_valid && out_ready`.
- Conversion is combinational on `in_data` at push; the FIFO stores the converted value plus the saturation bit.
  - `s = in_data >>> SHIFT`: arithmetic shift, floor rounding.
  - If `relu_en` and `s < 0`: `s = 0`, not flagged as saturation.
  - If `s > 2^(M-1)-1`: result is `2^(M-1)-1` with sat=1. If `s < -2^(M-1)`: result is `-2^(M-1)` with sat=1. Otherwise the result is `s[M-1:0]` with sat=0.
- FIFO: write pointer and read pointer, each `log2(DEPTH)` bits, wrapping modulo DEPTH. `count` is tracked separately.
  - Full: `count==DEPTH`, so `in_ready=0`.
  - Empty: `count==0`, so `out_valid=0`.
- Simultaneous push and pop: both pointers advance and `count` is unchanged. Because `in_ready` depends only on `count`, push is blocked when full even if a pop occurs in the same cycle.
- `out_data` and `out_sat` come from a registered head. They are held stable while `out_valid && !out_ready`.
- `sat_sticky`: set on a push with sat=1, cleared by `sat_clr`. If set and clear occur in the same cycle, set wins.
- Reset (any time, including mid-stream) empties the FIFO. All buffered data is discarded and no partial handshake completes.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `out_data=0`, `out_sat=0`, `count=0`, `sat_sticky=0`. Pointers are 0.
- Latency: a word pushed at edge t into an empty FIFO shows `out_valid=1` after edge t, i.e. one cycle.
- Throughput: one push and one pop per cycle in steady state when DEPTH ≥ 2.
- No combinational path from `out_ready` to `in_ready`, or from `in_valid` to `out_valid`.
- `in_data` and `relu_en` need only be valid in the push cycle.

## Structure
- Shared package `mlp_pkg` holds:
  - `ACC_W=21` and `ACT_W=8`, the defaults for `N` and `M`;
  - the default `SHIFT`;
  - saturation limit constants derived from `ACT_W`.
- One natural sub-module, `sat_shift`: combinational shift, ReLU and saturate. Inputs are `in_data` and `relu_en`; outputs are the result and sat. It is unit-testable on its own.
- The FIFO storage and pointer logic live in `acc_unloader`.

## Test plan
- Basic conversion: push `21'h003400`, `relu_en=0` → `out_data=8'h34`, `out_sat=0`, `out_valid` one cycle after the push.
- Positive saturation: push `21'h0F0000` → `out_data=8'h7F`, `out_sat=1`, `sat_sticky=1`. Then pulse `sat_clr` together with a push of `21'h000100` → `sat_sticky` stays 0 and out is `8'h01`.
- Negative values: push `-512` → `8'hFE`. Push `-40000` → `8'h80` with sat=1. Push `-512` with `relu_en=1` → `8'h00` with sat=0.
- Full and wrap-around: hold `out_ready=0` and push 5 words `1..5` (scaled by 256) → `in_ready=0` after 4 pushes and `count=4`. Release `out_ready` → outputs `1,2,3,4` in order. Then push/pop 10 more words → order preserved across pointer wrap.
- Simultaneous push/pop: with `count=2`, assert both handshakes for 6 cycles → `count` remains 2 and data order is preserved. Stall `out_ready` mid-stream → `out_data` is held stable.
- Reset mid-operation: with `count=3`, assert `rst_n=0` between clock edges → all outputs take their reset values immediately. After release, the first pushed word `21'h000500` emerges as `8'h05`.
